// File: rtl/psd_divide_core.sv
// Iterative restoring unsigned divider: one quotient bit per clock after start,
// result committed to quotient/rest on stop. Optional div0 flag under PSD_DIVIDE_DIV0_FLAG_EN.
module psd_divide_core #(
  parameter int NBITS = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [NBITS-1:0] dividend,
  input  logic [NBITS-1:0] divisor,
  output logic [NBITS-1:0] quotient,
  output logic [NBITS-1:0] rest,
  output logic             done,
  output logic             valid
`ifdef PSD_DIVIDE_DIV0_FLAG_EN
  ,
  output logic             div0
`endif
);

  localparam int CW = $clog2(NBITS + 1);

  // Handshake: start is a one-edge command that always wins; stop commits only
  // while done is high and start is low; valid pulses for exactly the committing cycle.
  logic [2*NBITS-1:0] rdiv_q, rdiv_d;
  logic [NBITS-1:0]   rdivisor_q, rdivisor_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               loaded_q, loaded_d;
  logic [NBITS-1:0]   quotient_q, quotient_d;
  logic [NBITS-1:0]   rest_q, rest_d;
  logic               done_q, done_d;
  logic               valid_q, valid_d;
  logic               div0_d;

  logic [NBITS:0]     upper_ext;
  logic [NBITS-1:0]   diff_lo;
  logic               trial_ok;

  // The upper half after the shift needs NBITS+1 bits to keep the carried-out MSB.
  assign upper_ext = rdiv_q[2*NBITS-1:NBITS-1];
  assign trial_ok  = (upper_ext >= {1'b0, rdivisor_q});
  assign diff_lo   = rdiv_q[2*NBITS-2:NBITS-1] - rdivisor_q;

  always_comb begin
    rdiv_d     = rdiv_q;
    rdivisor_d = rdivisor_q;
    cnt_d      = cnt_q;
    loaded_d   = loaded_q;
    quotient_d = quotient_q;
    rest_d     = rest_q;
    done_d     = done_q;
    valid_d    = 1'b0;
    div0_d     = 1'b0;
    if (start) begin
      rdiv_d     = {{NBITS{1'b0}}, dividend};
      rdivisor_d = divisor;
      cnt_d      = CW'(NBITS);
      loaded_d   = 1'b1;
      done_d     = 1'b0;
    end else begin
      if (cnt_q != '0) begin
        if (trial_ok) rdiv_d = {diff_lo, rdiv_q[NBITS-2:0], 1'b1};
        else          rdiv_d = {rdiv_q[2*NBITS-2:0], 1'b0};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) done_d = 1'b1;
      end
      if (stop && done_q && loaded_q && cnt_q == '0) begin
        quotient_d = rdiv_q[NBITS-1:0];
        rest_d     = rdiv_q[2*NBITS-1:NBITS];
        valid_d    = 1'b1;
        div0_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdiv_q     <= '0;
      rdivisor_q <= '0;
      cnt_q      <= '0;
      loaded_q   <= 1'b0;
      quotient_q <= '0;
      rest_q     <= '0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      rdiv_q     <= rdiv_d;
      rdivisor_q <= rdivisor_d;
      cnt_q      <= cnt_d;
      loaded_q   <= loaded_d;
      quotient_q <= quotient_d;
      rest_q     <= rest_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
    end
  end

  assign quotient = quotient_q;
  assign rest     = rest_q;
  assign done     = done_q;
  assign valid    = valid_q;

`ifdef PSD_DIVIDE_DIV0_FLAG_EN
  logic div0_q;
  // div0_d marks a commit; the flag itself is taken from the latched divisor.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       div0_q <= 1'b0;
    else if (div0_d) div0_q <= (rdivisor_q == '0);
  end
  assign div0 = div0_q;
`else
  logic unused_div0;
  assign unused_div0 = div0_d;
`endif

endmodule

// File: tb/tb_psd_divide_core.sv
// Bench for psd_divide_core at NBITS=8: vector table, randomized divisions
// against an arithmetic model, and hand-written multi-cycle corner sequences.
module tb_psd_divide_core;

  localparam int W = 8;

  logic         clock;
  logic         reset;
  logic         start;
  logic         stop;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] rest;
  logic         done;
  logic         valid;
`ifdef PSD_DIVIDE_DIV0_FLAG_EN
  logic         div0;
`endif

  psd_divide_core #(.NBITS(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .dividend (dividend),
    .divisor  (divisor),
    .quotient (quotient),
    .rest     (rest),
    .done     (done),
    .valid    (valid)
`ifdef PSD_DIVIDE_DIV0_FLAG_EN
    ,
    .div0     (div0)
`endif
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required run to finish");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int n_pass  = 0;
  int n_total = 0;
  logic [2*W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", name, act, exp);
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == 0) return {{W{1'b1}}, a};
    return {W'(a / b), W'(a % b)};
  endfunction

  // driver: apply inputs for one edge, then sample 1 time unit after it
  task automatic edge_with(input logic s, input logic p, input logic [W-1:0] a, input logic [W-1:0] b);
    start = s; stop = p; dividend = a; divisor = b;
    @(posedge clock);
    #1;
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) edge_with(1'b0, 1'b0, '0, '0);
  endtask

  task automatic check_commit(input string tag);
    logic [2*W-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 0, 1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_quotient"}, quotient, e[2*W-1:W]);
    check({tag, "_rest"}, rest, e[W-1:0]);
    check({tag, "_valid"}, valid, 1);
  endtask

  // Full division: start at E0, done checked at E7/E8, stop at E9, idle E10.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    exp_q.push_back(model(a, b));
    edge_with(1'b1, 1'b0, a, b);
    idle(7);
    check({tag, "_done_e7"}, done, 0);
    idle(1);
    check({tag, "_done_e8"}, done, 1);
    edge_with(1'b0, 1'b1, '0, '0);
    check_commit(tag);
    idle(1);
    check({tag, "_valid_e10"}, valid, 0);
    check({tag, "_done_e10"}, done, 1);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [W-1:0] ra, rb;
    logic [2*W-1:0] m;

    vecs[0] = '{a: 8'd100, b: 8'd7,   q: 8'd14,  r: 8'd2};
    vecs[1] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0};
    vecs[2] = '{a: 8'd5,   b: 8'd0,   q: 8'd255, r: 8'd5};
    vecs[3] = '{a: 8'd200, b: 8'd9,   q: 8'd22,  r: 8'd2};
    vecs[4] = '{a: 8'd250, b: 8'd200, q: 8'd1,   r: 8'd50};
    vecs[5] = '{a: 8'd3,   b: 8'd255, q: 8'd0,   r: 8'd3};

    start = 0; stop = 0; dividend = 0; divisor = 0;
    reset = 1'b1;
    #12;
    check("reset_quotient", quotient, 0);
    check("reset_rest", rest, 0);
    check("reset_done", done, 0);
    check("reset_valid", valid, 0);
`ifdef PSD_DIVIDE_DIV0_FLAG_EN
    check("reset_div0", div0, 0);
`endif
    reset = 1'b0;
    @(posedge clock); #1;

    // stop before any start is ignored
    edge_with(1'b0, 1'b1, '0, '0);
    check("stop_unloaded_valid", valid, 0);
    check("stop_unloaded_quotient", quotient, 0);

    // table vectors
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({vecs[i].q, vecs[i].r});
      edge_with(1'b1, 1'b0, vecs[i].a, vecs[i].b);
      idle(8);
      check("vec_done", done, 1);
      edge_with(1'b0, 1'b1, '0, '0);
      check_commit("vec");
`ifdef PSD_DIVIDE_DIV0_FLAG_EN
      check("vec_div0", div0, (vecs[i].b == 0) ? 1 : 0);
`endif
      idle(1);
    end

    // 100/7 with full timing
    run_div(8'd100, 8'd7, "d100_7");

    // 255/1 then recommit at E12
    run_div(8'd255, 8'd1, "d255_1");
    idle(1);
    check("recommit_valid_e11", valid, 0);
    exp_q.push_back({8'd255, 8'd0});
    edge_with(1'b0, 1'b1, '0, '0);
    check_commit("recommit_e12");

    // 5/0
    run_div(8'd5, 8'd0, "d5_0");
`ifdef PSD_DIVIDE_DIV0_FLAG_EN
    check("d5_0_div0", div0, 1);
`endif

    // early stop at E4 ignored, stop at E9 commits
    edge_with(1'b1, 1'b0, 8'd100, 8'd7);
    idle(3);
    edge_with(1'b0, 1'b1, '0, '0);
    check("early_stop_valid", valid, 0);
    check("early_stop_quotient", quotient, 255);
    check("early_stop_rest", rest, 5);
    idle(4);
    exp_q.push_back({8'd14, 8'd2});
    edge_with(1'b0, 1'b1, '0, '0);
    check_commit("early_stop_e9");
`ifdef PSD_DIVIDE_DIV0_FLAG_EN
    check("early_stop_div0", div0, 0);
`endif

    // abort: restart with 200/9 at E3, stop at E12
    edge_with(1'b1, 1'b0, 8'd100, 8'd7);
    idle(2);
    edge_with(1'b1, 1'b0, 8'd200, 8'd9);
    check("abort_quotient_hold", quotient, 14);
    check("abort_rest_hold", rest, 2);
    idle(7);
    check("abort_done_e10", done, 0);
    idle(1);
    check("abort_done_e11", done, 1);
    exp_q.push_back({8'd22, 8'd2});
    edge_with(1'b0, 1'b1, '0, '0);
    check_commit("abort_e12");

    // start and stop on the same edge: start wins
    edge_with(1'b1, 1'b1, 8'd50, 8'd3);
    check("same_edge_valid", valid, 0);
    check("same_edge_done", done, 0);
    check("same_edge_quotient", quotient, 22);
    idle(8);
    exp_q.push_back(model(8'd50, 8'd3));
    edge_with(1'b0, 1'b1, '0, '0);
    check_commit("same_edge_e9");

    // reset mid-iteration
    edge_with(1'b1, 1'b0, 8'd100, 8'd7);
    idle(4);
    reset = 1'b1;
    #2;
    check("midreset_async_quotient", quotient, 0);
    check("midreset_async_rest", rest, 0);
    reset = 1'b0;
    idle(4);
    edge_with(1'b0, 1'b1, '0, '0);
    check("midreset_quotient", quotient, 0);
    check("midreset_rest", rest, 0);
    check("midreset_valid", valid, 0);
    check("midreset_done", done, 0);
`ifdef PSD_DIVIDE_DIV0_FLAG_EN
    check("midreset_div0", div0, 0);
`endif

    // randomized divisions against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = (i % 8 == 0) ? 8'd0 : W'($urandom_range(0, 255));
      m  = model(ra, rb);
      exp_q.push_back(m);
      edge_with(1'b1, 1'b0, ra, rb);
      idle(8 + $urandom_range(0, 3));
      edge_with(1'b0, 1'b1, '0, '0);
      check_commit("rand");
      idle($urandom_range(0, 2));
      check("rand_hold_quotient", quotient, m[2*W-1:W]);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
